// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// shifts a byte plus odd parity on device clock edges and checks the device ack.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2400,
    parameter int unsigned TIMEOUT_CYCLES = 48000,
    parameter int unsigned FILTER_LEN     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       ps2_clk_low,
    output logic       ps2_dat_low,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE
    } state_t;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          clk_f, clk_f_d;
    logic [FW-1:0] flt_cnt;
    logic          fall;

    state_t        state_q, state_n;
    logic [7:0]    data_q, data_n;
    logic          par_q, par_n;
    logic [3:0]    edge_q, edge_n;
    logic [IW-1:0] inh_q, inh_n;
    logic [TW-1:0] tout_q, tout_n;
    logic          ack_err_q, ack_err_n;
    logic          clk_low_n, dat_low_n, busy_n, done_n, error_n;

    // Pin synchronizers and clock deglitch filter; idle bus level is 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            clk_f   <= 1'b1;
            clk_f_d <= 1'b1;
            flt_cnt <= '0;
        end else begin
            clk_s1  <= PS2_CLK;
            clk_s2  <= clk_s1;
            dat_s1  <= PS2_DAT;
            dat_s2  <= dat_s1;
            clk_f_d <= clk_f;
            if (clk_s2 != clk_f) begin
                if (flt_cnt == FW'(FILTER_LEN - 1)) begin
                    clk_f   <= clk_s2;
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + FW'(1);
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall = clk_f_d & ~clk_f;

    // State, datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            data_q      <= '0;
            par_q       <= 1'b0;
            edge_q      <= '0;
            inh_q       <= '0;
            tout_q      <= '0;
            ack_err_q   <= 1'b0;
            ps2_clk_low <= 1'b0;
            ps2_dat_low <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_n;
            data_q      <= data_n;
            par_q       <= par_n;
            edge_q      <= edge_n;
            inh_q       <= inh_n;
            tout_q      <= tout_n;
            ack_err_q   <= ack_err_n;
            ps2_clk_low <= clk_low_n;
            ps2_dat_low <= dat_low_n;
            busy        <= busy_n;
            done        <= done_n;
            error       <= error_n;
        end
    end

    // Next-state logic; line outputs are computed one cycle ahead of the state they belong to.
    always_comb begin
        state_n   = state_q;
        data_n    = data_q;
        par_n     = par_q;
        edge_n    = edge_q;
        inh_n     = inh_q;
        tout_n    = tout_q;
        ack_err_n = ack_err_q;
        clk_low_n = ps2_clk_low;
        dat_low_n = ps2_dat_low;
        busy_n    = busy;
        done_n    = 1'b0;
        error_n   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_low_n = 1'b0;
                dat_low_n = 1'b0;
                busy_n    = 1'b0;
                if (tx_start) begin
                    data_n    = tx_data;
                    par_n     = ~^tx_data;
                    busy_n    = 1'b1;
                    inh_n     = '0;
                    edge_n    = '0;
                    clk_low_n = 1'b1;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
                    clk_low_n = 1'b0;
                    dat_low_n = 1'b1;
                    tout_n    = '0;
                    state_n   = REQ;
                end else begin
                    inh_n     = inh_q + IW'(1);
                    clk_low_n = 1'b1;
                    dat_low_n = (inh_q == IW'(INHIBIT_CYCLES - 2));
                end
            end
            REQ, DATA, ACK, WAIT_IDLE: begin
                tout_n = fall ? '0 : tout_q + TW'(1);
                if (tout_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    clk_low_n = 1'b0;
                    dat_low_n = 1'b0;
                    done_n    = 1'b1;
                    error_n   = 1'b1;
                    busy_n    = 1'b0;
                    state_n   = IDLE;
                end else begin
                    case (state_q)
                        REQ: begin
                            if (fall) begin
                                dat_low_n = ~data_q[0];
                                edge_n    = 4'd1;
                                state_n   = DATA;
                            end
                        end
                        DATA: begin
                            if (fall) begin
                                edge_n = edge_q + 4'd1;
                                if (edge_q == 4'd8) begin
                                    dat_low_n = ~par_q;
                                end else if (edge_q == 4'd9) begin
                                    dat_low_n = 1'b0;
                                    state_n   = ACK;
                                end else begin
                                    dat_low_n = ~data_q[edge_q[2:0]];
                                end
                            end
                        end
                        ACK: begin
                            if (fall) begin
                                ack_err_n = dat_s2;
                                edge_n    = edge_q + 4'd1;
                                state_n   = WAIT_IDLE;
                            end
                        end
                        WAIT_IDLE: begin
                            if (clk_f && dat_s2) begin
                                done_n  = 1'b1;
                                error_n = ack_err_q;
                                busy_n  = 1'b0;
                                state_n = IDLE;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 keyboard model clocks frames out of the host and
// checks each frame against the expected start/data/parity/stop pattern.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk_low, ps2_dat_low, busy, done, error;
    logic       ps2_clk_line, ps2_dat_line;

    // Open-drain bus with pull-ups: either side may pull a line low.
    assign ps2_clk_line = ~ps2_clk_low & dev_clk;
    assign ps2_dat_line = ~ps2_dat_low & dev_dat;

    ps2_host_tx dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .PS2_CLK    (ps2_clk_line),
        .PS2_DAT    (ps2_dat_line),
        .ps2_clk_low(ps2_clk_low),
        .ps2_dat_low(ps2_dat_low),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic       done_err = 1'b0;
    logic [1:0] done_lines = 2'b00;
    int         low_run = 0;
    int         inh_len = 0;
    int         req_cyc = 0;
    logic [1:0] dat_hist = 2'b00;
    logic [1:0] inh_pat = 2'b00;
    logic       prev_clk_low = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: done pulses and length/shape of each clock-inhibit period.
    always @(negedge clk) begin
        if (done) begin
            done_cnt   <= done_cnt + 1;
            done_err   <= error;
            done_cyc   <= cyc;
            done_lines <= {ps2_clk_low, ps2_dat_low};
        end
        if (ps2_clk_low) begin
            low_run  <= low_run + 1;
            dat_hist <= {dat_hist[0], ps2_dat_low};
        end else if (prev_clk_low) begin
            inh_len <= low_run;
            inh_pat <= dat_hist;
            req_cyc <= cyc;
            low_run <= 0;
        end
        prev_clk_low <= ps2_clk_low;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame as seen on the data line: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] exp_frame(input logic [7:0] d);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = d[i];
        f[9]  = ($countones(d) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        chk("idle_not_busy", 32'(busy), 32'd0);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("done_seen", 32'(done_cnt >= target), 32'd1);
    endtask

    // Keyboard model: waits for request-to-send, then clocks n_edges falling edges,
    // sampling the data line late in each high phase.
    task automatic device_frame(input int n_edges, input bit ack, input bit glitch,
                                input int hp, input int rst_at, output logic [10:0] fr);
        bit found = 1'b0;
        fr = '1;
        for (int k = 0; k < 4000 && !found; k++) begin
            @(negedge clk);
            if (!ps2_clk_low && ps2_dat_low && busy) found = 1'b1;
        end
        chk("req_seen", 32'(found), 32'd1);
        if (!found) return;
        fr[0] = ps2_dat_line;
        repeat (hp) @(negedge clk);
        for (int i = 1; i <= n_edges; i++) begin
            dev_clk = 1'b0;
            if (i == 11 && ack) dev_dat = 1'b0;
            for (int j = 0; j < hp; j++) begin
                @(negedge clk);
                if (glitch && j == hp / 2)     dev_clk = 1'b1;
                if (glitch && j == hp / 2 + 3) dev_clk = 1'b0;
            end
            if (i == rst_at) begin
                reset = 1'b1;
                @(negedge clk);
                reset   = 1'b0;
                dev_clk = 1'b1;
                dev_dat = 1'b1;
                chk("rst_clk_low", 32'(ps2_clk_low), 32'd0);
                chk("rst_dat_low", 32'(ps2_dat_low), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                return;
            end
            dev_clk = 1'b1;
            for (int j = 0; j < hp; j++) begin
                @(negedge clk);
                if (glitch && j == hp / 2)     dev_clk = 1'b0;
                if (glitch && j == hp / 2 + 3) dev_clk = 1'b1;
                if (glitch && i == 3) begin
                    if (j == 2) tx_data = 8'h5A;
                    tx_start = (j == 2);
                end
                if (j == hp - 2 && i <= 10) fr[i] = ps2_dat_line;
            end
            if (i == 11) dev_dat = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit ack, input bit glitch,
                              output logic [10:0] fr);
        int base = done_cnt;
        int hp = int'($urandom_range(16, 28));
        start_tx(d);
        device_frame(11, ack, glitch, hp, 0, fr);
        chk("frame_bits", 32'(fr), 32'(exp_frame(d)));
        wait_done(base + 1, 300);
        chk("done_error", 32'(done_err), 32'(!ack));
        chk("done_lines_released", 32'(done_lines), 32'd0);
        chk("inhibit_len", 32'(inh_len), 32'd2400);
        chk("inhibit_dat_tail", 32'(inh_pat), 32'b01);
        repeat (40) @(negedge clk);
        chk("single_done", 32'(done_cnt - base), 32'd1);
        chk("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [10:0] fr;
        int          base;

        repeat (5) @(negedge clk);
        chk("reset_clk_low", 32'(ps2_clk_low), 32'd0);
        chk("reset_dat_low", 32'(ps2_dat_low), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_error", 32'(error), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);

        send_frame(8'hED, 1'b1, 1'b0, fr);
        chk("ed_bits", 32'(fr), 32'b1_1_11101101_0);

        send_frame(8'h01, 1'b1, 1'b0, fr);
        chk("parity_01", 32'(fr[9]), 32'd0);
        send_frame(8'h00, 1'b1, 1'b0, fr);
        chk("parity_00", 32'(fr[9]), 32'd1);

        // Silent device: request-to-send must time out.
        base = done_cnt;
        start_tx(8'h3C);
        device_frame(0, 1'b0, 1'b0, 16, 0, fr);
        wait_done(base + 1, 50000);
        chk("timeout_latency", 32'(done_cyc - req_cyc), 32'd48000);
        chk("timeout_error", 32'(done_err), 32'd1);
        chk("timeout_lines", 32'(done_lines), 32'd0);

        send_frame(8'hA7, 1'b0, 1'b0, fr);

        send_frame(8'h96, 1'b1, 1'b1, fr);

        // Reset mid-frame: no done, then a fresh transmission works.
        base = done_cnt;
        start_tx(8'hC3);
        device_frame(11, 1'b1, 1'b0, 20, 5, fr);
        repeat (300) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(base));
        send_frame(8'h5E, 1'b1, 1'b0, fr);

        for (int r = 0; r < 2; r++) begin
            send_frame(8'($urandom), 1'b1, 1'b0, fr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
